layer_sched: RTL

//  Top-level layer sequencer for the LeNet accelerator. It starts each layer engine
//  (conv1, pool1, conv2, pool2, full_conn) in order and waits for each one's done pulse.
//  It grants the single DRAM port to the active engine only, and reports busy/done/error to the host.

---
 rtl/lenet_pkg.sv | 23 ++
 rtl/dram_port_mux.sv | 39 +++
 rtl/layer_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared constants and FSM state encoding for the LeNet layer sequencer.
package lenet_pkg;

    localparam int NUM_LAYERS_DFLT = 5;
    localparam int ADDR_WIDTH_DFLT = 18;
    localparam int DATA_WIDTH_DFLT = 32;

    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_SEEK   = 6'b000010,
        ST_LAUNCH = 6'b000100,
        ST_RUN    = 6'b001000,
        ST_DONE   = 6'b010000,
        ST_ERR    = 6'b100000
    } sched_state_t;

endpackage

// File: rtl/dram_port_mux.sv
// N:1 combinational grant mux for the shared DRAM port; all outputs are 0 when gate is low.
module dram_port_mux #(
    parameter int N  = 5,
    parameter int AW = 18,
    parameter int DW = 32,
    parameter int SW = 3
) (
    input  logic [SW-1:0]   sel_i,
    input  logic            gate_i,
    input  logic [N*AW-1:0] addr_in_i,
    input  logic [N*AW-1:0] addr_out_i,
    input  logic [N*DW-1:0] data_out_i,
    input  logic [N-1:0]    en_rd_i,
    input  logic [N-1:0]    en_wr_i,
    output logic [AW-1:0]   addr_in_o,
    output logic [AW-1:0]   addr_out_o,
    output logic [DW-1:0]   data_out_o,
    output logic            en_rd_o,
    output logic            en_wr_o
);

    always_comb begin
        addr_in_o  = '0;
        addr_out_o = '0;
        data_out_o = '0;
        en_rd_o    = 1'b0;
        en_wr_o    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gate_i && (sel_i == SW'(i))) begin
                addr_in_o  = addr_in_i[i*AW +: AW];
                addr_out_o = addr_out_i[i*AW +: AW];
                data_out_o = data_out_i[i*DW +: DW];
                en_rd_o    = en_rd_i[i];
                en_wr_o    = en_wr_i[i];
            end
        end
    end

endmodule

// File: rtl/layer_sched.sv
// Layer sequencer: launches each unmasked engine in order, waits for its done pulse,
// guards each layer with a watchdog, and grants the DRAM port only to the active engine.
module layer_sched
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DFLT,
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int TMO_WIDTH  = 24,
    parameter logic [TMO_WIDTH-1:0] TMO_LIMIT = '1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUM_LAYERS-1:0]          layer_mask,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [2:0]                     err_layer,
    output logic [31:0]                    run_cycles,
    output logic [NUM_LAYERS-1:0]          layer_enable,
    input  logic [NUM_LAYERS-1:0]          layer_done,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lyr_addr_in,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lyr_addr_out,
    input  logic [NUM_LAYERS*DATA_WIDTH-1:0] lyr_data_out,
    input  logic [NUM_LAYERS-1:0]          lyr_en_rd,
    input  logic [NUM_LAYERS-1:0]          lyr_en_wr,
    output logic [ADDR_WIDTH-1:0]          dram_addr_in,
    output logic [ADDR_WIDTH-1:0]          dram_addr_out,
    output logic [DATA_WIDTH-1:0]          dram_data_out,
    output logic                           dram_en_rd,
    output logic                           dram_en_wr,
    output logic [5:0]                     dbg_state_o
);

    localparam int IW = $clog2(NUM_LAYERS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LAYERS);

    sched_state_t            state_q;
    logic [IW-1:0]           idx_q;
    logic [NUM_LAYERS-1:0]   mask_q;
    logic [TMO_WIDTH-1:0]    wdog_q;
    logic [31:0]             run_cycles_q;
    logic                    err_q;
    logic [2:0]              err_layer_q;
    logic                    done_q;
    logic [NUM_LAYERS-1:0]   enable_q;
    logic                    grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            mask_q       <= '0;
            wdog_q       <= '0;
            run_cycles_q <= '0;
            err_q        <= 1'b0;
            err_layer_q  <= '0;
            done_q       <= 1'b0;
            enable_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            enable_q <= '0;
            if (state_q != ST_IDLE && run_cycles_q != '1)
                run_cycles_q <= run_cycles_q + 32'd1;
            if (abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q      <= ST_SEEK;
                            mask_q       <= layer_mask;
                            idx_q        <= '0;
                            err_q        <= 1'b0;
                            err_layer_q  <= '0;
                            run_cycles_q <= '0;
                        end
                    end
                    ST_SEEK: begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (!mask_q[idx_q]) begin
                            idx_q <= idx_q + 1'b1;
                        end else begin
                            state_q  <= ST_LAUNCH;
                            enable_q <= NUM_LAYERS'(1) << idx_q;
                        end
                    end
                    ST_LAUNCH: begin
                        wdog_q  <= '0;
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        // A done in the same cycle as expiry still counts as success.
                        if (layer_done[idx_q]) begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_SEEK;
                        end else if (wdog_q == TMO_LIMIT) begin
                            state_q     <= ST_ERR;
                            err_q       <= 1'b1;
                            err_layer_q <= 3'(idx_q);
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    ST_DONE:  state_q <= ST_IDLE;
                    ST_ERR:   state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Abort drops the grant in the same cycle, before the FSM reaches IDLE.
    assign grant = (state_q == ST_LAUNCH || state_q == ST_RUN) && !abort;

    dram_port_mux #(
        .N  (NUM_LAYERS),
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH),
        .SW (IW)
    ) u_mux (
        .sel_i      (idx_q),
        .gate_i     (grant),
        .addr_in_i  (lyr_addr_in),
        .addr_out_i (lyr_addr_out),
        .data_out_i (lyr_data_out),
        .en_rd_i    (lyr_en_rd),
        .en_wr_i    (lyr_en_wr),
        .addr_in_o  (dram_addr_in),
        .addr_out_o (dram_addr_out),
        .data_out_o (dram_data_out),
        .en_rd_o    (dram_en_rd),
        .en_wr_o    (dram_en_wr)
    );

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign err_layer    = err_layer_q;
    assign run_cycles   = run_cycles_q;
    assign layer_enable = enable_q;
    assign dbg_state_o  = state_q;

endmodule
